sram_req_arbiter: RTL and testbench

//  Shares one SRAM-like memory port between the fetch (inst) and MEM-stage (data) requesters.

---
 rtl/sram_req_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Arbitrates the inst and data requesters onto one SRAM-like port and steers
// in-order responses back through an ID FIFO of accepted-but-unreturned requests.
module sram_req_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_unexp_rsp
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(OUTSTANDING - 1);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  logic                   lock_q, lock_d;
  logic                   locked_id_q, locked_id_d;
  logic [STV_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [OUTSTANDING-1:0] id_mem_q, id_mem_d;
  logic                   err_q, err_d;

  logic grant_vld, grant_id, granted_req, handshake;
  logic fifo_empty, push, pop, head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A held lock wins over everything; the starvation override only applies otherwise.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = ID_INST;
    if (lock_q) begin
      grant_vld = 1'b1;
      grant_id  = locked_id_q;
    end else if (starve_cnt_q == STARVE_MAX && inst_req) begin
      grant_vld = 1'b1;
      grant_id  = ID_INST;
    end else if (data_req) begin
      grant_vld = 1'b1;
      grant_id  = ID_DATA;
    end else if (inst_req) begin
      grant_vld = 1'b1;
      grant_id  = ID_INST;
    end
  end

  assign granted_req = grant_vld && ((grant_id == ID_DATA) ? data_req : inst_req);
  assign mem_req     = granted_req && (count_q != CNT_FULL);
  assign handshake   = mem_req && mem_addr_ok;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = 32'd0;
    mem_wstrb = 4'd0;
    mem_wdata = 32'd0;
    if (grant_vld && grant_id == ID_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wstrb = data_wstrb;
      mem_wdata = data_wdata;
    end else if (grant_vld) begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_addr  = inst_addr;
      mem_wstrb = inst_wstrb;
      mem_wdata = inst_wdata;
    end
  end

  assign inst_addr_ok = handshake && (grant_id == ID_INST);
  assign data_addr_ok = handshake && (grant_id == ID_DATA);

  assign fifo_empty = (count_q == '0);
  assign push       = handshake;
  assign pop        = mem_data_ok && !fifo_empty;
  assign head_id    = id_mem_q[rd_ptr_q];

  assign inst_data_ok  = pop && (head_id == ID_INST);
  assign data_data_ok  = pop && (head_id == ID_DATA);
  assign inst_rdata    = mem_rdata;
  assign data_rdata    = mem_rdata;
  assign err_unexp_rsp = err_q;

  genvar gi;
  generate
    for (gi = 0; gi < OUTSTANDING; gi++) begin : g_id_mem
      assign id_mem_d[gi] = (push && wr_ptr_q == PTR_W'(gi)) ? grant_id : id_mem_q[gi];
    end
  endgenerate

  always_comb begin
    lock_d       = lock_q;
    locked_id_d  = locked_id_q;
    starve_cnt_d = starve_cnt_q;
    wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d      = count_q;
    err_d        = err_q || (mem_data_ok && fifo_empty);

    if (handshake) begin
      lock_d = 1'b0;
    end else if (mem_req) begin
      lock_d      = 1'b1;
      locked_id_d = grant_id;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Only a lost handshake counts as a starvation cycle; idle memory does not.
    if (!inst_req) begin
      starve_cnt_d = '0;
    end else if (handshake && grant_id == ID_INST) begin
      starve_cnt_d = '0;
    end else if (handshake && starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q       <= 1'b0;
      locked_id_q  <= ID_INST;
      starve_cnt_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      id_mem_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      locked_id_q  <= locked_id_d;
      starve_cnt_q <= starve_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      id_mem_q     <= id_mem_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: a queue-based reference model checked every
// cycle, plus literal per-scenario expectations.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic        err_unexp_rsp;

  int n_checks = 0;
  int n_pass   = 0;

  sram_req_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: requester ids in acceptance order, pending (unaccepted) owner,
  // and the number of consecutive handshakes inst has lost.
  int   out_q[$];
  bit   pend;
  int   pend_id;
  int   lost;
  bit   err_m;

  always @(negedge clk) begin
    int   who;
    bit   req_on, e_req, hs, e_iok, e_dok;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_size;
    logic        e_wr;
    if (reset) begin
      out_q.delete();
      pend = 0; pend_id = 0; lost = 0; err_m = 0;
    end else begin
      who = -1;
      if (pend)                       who = pend_id;
      else if (lost >= 4 && inst_req) who = 0;
      else if (data_req)              who = 1;
      else if (inst_req)              who = 0;
      req_on = (who == 1) ? data_req : (who == 0) ? inst_req : 1'b0;
      e_req  = req_on && (out_q.size() < 2);
      hs     = e_req && mem_addr_ok;
      e_addr = 0; e_wdata = 0; e_wstrb = 0; e_size = 0; e_wr = 0;
      if (who == 1) begin
        e_addr = data_addr; e_wdata = data_wdata; e_wstrb = data_wstrb; e_size = data_size; e_wr = data_wr;
      end else if (who == 0) begin
        e_addr = inst_addr; e_wdata = inst_wdata; e_wstrb = inst_wstrb; e_size = inst_size; e_wr = inst_wr;
      end
      e_iok = mem_data_ok && out_q.size() > 0 && out_q[0] == 0;
      e_dok = mem_data_ok && out_q.size() > 0 && out_q[0] == 1;
      chk("m_mem_req", {31'd0, mem_req}, {31'd0, e_req});
      chk("m_mem_addr", mem_addr, e_addr);
      chk("m_mem_wdata", mem_wdata, e_wdata);
      chk("m_mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, e_wr, e_size, e_wstrb});
      chk("m_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, {30'd0, hs && who == 0, hs && who == 1});
      chk("m_data_ok", {30'd0, inst_data_ok, data_data_ok}, {30'd0, e_iok, e_dok});
      chk("m_err", {31'd0, err_unexp_rsp}, {31'd0, err_m});
      if (e_iok) chk("m_inst_rdata", inst_rdata, mem_rdata);
      if (e_dok) chk("m_data_rdata", data_rdata, mem_rdata);
      // advance model to the state after the coming posedge
      if (mem_data_ok && out_q.size() == 0) err_m = 1;
      if (mem_data_ok && out_q.size() > 0) void'(out_q.pop_front());
      if (hs) out_q.push_back(who);
      if (hs) pend = 0;
      else if (e_req) begin pend = 1; pend_id = who; end
      if (!inst_req) lost = 0;
      else if (hs && who == 0) lost = 0;
      else if (hs && lost < 4) lost++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    idle();
    tick(); tick();
    reset = 0;
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
    chk("rst_err", {31'd0, err_unexp_rsp}, 0);
    tick();

    // 1: single data read
    data_req = 1; data_addr = 32'h1000; mem_addr_ok = 1;
    @(negedge clk);
    chk("t1_data_addr_ok", {31'd0, data_addr_ok}, 1);
    chk("t1_mem_addr", mem_addr, 32'h1000);
    tick();
    idle(); tick();
    mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_data_data_ok", {31'd0, data_data_ok}, 1);
    chk("t1_data_rdata", data_rdata, 32'hDEADBEEF);
    chk("t1_inst_data_ok", {31'd0, inst_data_ok}, 0);
    tick(); idle(); tick();

    // 2: simultaneous requests
    inst_req = 1; inst_addr = 32'h0400; data_req = 1; data_addr = 32'h0800; mem_addr_ok = 1;
    @(negedge clk);
    chk("t2_c0_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    tick();
    data_req = 0;
    @(negedge clk);
    chk("t2_c1_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1111;
    @(negedge clk);
    chk("t2_rsp0", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    tick();
    mem_rdata = 32'h2222;
    @(negedge clk);
    chk("t2_rsp1", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
    tick(); idle(); tick();

    // 3: lock holds inst despite data arriving
    inst_req = 1; inst_addr = 32'h2000;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin data_req = 1; data_addr = 32'h3000; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'h55AA55AA; end
      mem_addr_ok = (c >= 3);
      if (c == 4) inst_req = 0;
      @(negedge clk);
      if (c < 4) chk("t3_mem_addr", mem_addr, 32'h2000);
      if (c == 3) chk("t3_inst_ok", {31'd0, inst_addr_ok}, 1);
      if (c == 4) begin
        chk("t3_data_ok", {31'd0, data_addr_ok}, 1);
        chk("t3_data_addr", mem_addr, 32'h3000);
      end
      tick();
    end
    idle(); mem_data_ok = 1; mem_rdata = 32'hA;
    @(negedge clk);
    chk("t3_rsp_inst", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
    tick();
    @(negedge clk);
    chk("t3_rsp_data", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    tick(); idle(); tick();

    // 4: starvation guard
    inst_req = 1; inst_addr = 32'h4000; data_req = 1; data_addr = 32'h5000; mem_addr_ok = 1;
    for (int c = 0; c < 6; c++) begin
      mem_data_ok = (c >= 1); mem_rdata = 32'h100 + c;
      @(negedge clk);
      chk("t4_grant", {30'd0, inst_addr_ok, data_addr_ok}, (c == 4) ? 32'd2 : 32'd1);
      tick();
    end
    idle(); mem_data_ok = 1;
    @(negedge clk);
    chk("t4_last_rsp", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    tick(); idle(); tick();

    // 5: FIFO full blocks issue, including a same-cycle pop
    data_req = 1; data_addr = 32'h6000; data_wr = 1; data_wstrb = 4'b0011; data_wdata = 32'hCAFE0000;
    mem_addr_ok = 1;
    for (int c = 0; c < 5; c++) begin
      mem_data_ok = (c == 3);
      @(negedge clk);
      chk("t5_mem_req", {31'd0, mem_req}, (c == 2 || c == 3) ? 32'd0 : 32'd1);
      chk("t5_data_aok", {31'd0, data_addr_ok}, (c == 2 || c == 3) ? 32'd0 : 32'd1);
      tick();
    end
    idle(); mem_data_ok = 1;
    tick(); tick();
    idle(); tick();

    // 6: reset with a transaction in flight, then an orphan response
    data_req = 1; data_addr = 32'h7000; mem_addr_ok = 1;
    tick();
    do_reset();
    mem_data_ok = 1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("t6_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
    chk("t6_err_before", {31'd0, err_unexp_rsp}, 0);
    tick();
    mem_data_ok = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_err_sticky", {31'd0, err_unexp_rsp}, 1);
      tick();
    end
    do_reset();
    @(negedge clk);
    chk("t6_err_cleared", {31'd0, err_unexp_rsp}, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
